pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//   Generic pipeline stage register for the 5-stage MIPS core (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Carries one control bundle plus DATA_LANES data words.
//   Implements stall (hold), flush (kill), and bubble insertion (zeroed control, data passes).
//   A stall watchdog flags stuck stalls.
//   Replaces ad-hoc stage latches and the separate control-zeroing mux.
// PARAMETERS
//   DATA_W      32  width of each data lane (bits)
//   DATA_LANES  4   number of data lanes, e.g. ID/EX: PC+4, rs_val, rt_val, sext imm
//   CTRL_W      9   control bundle width (RegWrite..ALUSrc, ALUOp[1:0])
//   STALL_LIMIT 15  consecutive stall cycles before stall_timeout asserts; 1..255
// PORTS
//   clk            in   1                  rising-edge clock
//   rst_n          in   1                  synchronous, active-low reset
//   stall_i        in   1                  hold current contents
//   flush_i        in   1                  kill stage contents (branch/jump taken)
//   bubble_i       in   1                  load data, force ctrl=0, valid=0 (load-use hazard)
//   in_valid       in   1                  upstream slot holds a real instruction
//   in_ctrl        in   CTRL_W             upstream control bundle
//   in_data        in   DATA_LANES*DATA_W  upstream data, lane k at [k*DATA_W +: DATA_W]
//   out_valid      out  1                  registered valid
//   out_ctrl       out  CTRL_W             registered control; always 0 when out_valid=0
//   out_data       out  DATA_LANES*DATA_W  registered data
//   out_state      out  2                  EMPTY=0, FULL=1, HELD=2
//   stall_timeout  out  1                  sticky; stall run reached STALL_LIMIT
// BEHAVIOUR
//   - All updates on posedge clk. Latency is 1 cycle in to out. No combinational in->out path.
//   - Reset (rst_n=0 at edge):
//       out_valid=0, out_ctrl=0, out_data=0, out_state=EMPTY.
//       stall_timeout=0, stall run counter=0, perf counters=0.
//     Reset overrides every other input. Contents held mid-stall are discarded.
//   - Priority per edge: flush_i > stall_i > bubble_i > normal load.
//     - flush: out_valid=0, out_ctrl=0, out_data=0 -> EMPTY. Flush during stall still kills.
//     - stall: all out_* hold. EMPTY stays EMPTY; FULL/HELD -> HELD.
//     - bubble: out_data<=in_data, out_ctrl=0, out_valid=0 -> EMPTY.
//     - load: out_data<=in_data, out_valid<=in_valid.
//       out_ctrl<=in_valid ? in_ctrl : 0.
//       -> FULL if in_valid, else EMPTY.
//   - HELD -> FULL on a load with in_valid=1; -> EMPTY on flush, bubble, or load with in_valid=0.
//   - Invariant: out_valid=0 implies out_ctrl=0, so no spurious RegWrite/MemWrite can occur.
//   - Stall run counter, 8 bits:
//       increments each edge with stall_i=1 and flush_i=0, saturating at 255;
//       clears on any non-stall edge.
//     stall_timeout sets when the counter reaches STALL_LIMIT.
//     It is cleared only by reset.
//   - in_data/in_ctrl are ignored when stall_i or flush_i is 1.
// CONFIGURATION
//   Macro PIPE_STAGE_PERF_EN.
//   Defined: adds two output ports, both 16-bit saturating counters (hold at 0xFFFF).
//     perf_stalls  counts edges taken as stall.
//     perf_kills   counts edges taken as flush or bubble where the old out_valid or in_valid was 1.
//   Undefined: the ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//   Shared package pipe_pkg:
//     CTRL_W default, control bundle bit offsets (REGWRITE_B ... ALUOP_LSB).
//     State encoding (ST_EMPTY, ST_FULL, ST_HELD).
//     Stage action enum (ACT_LOAD, ACT_STALL, ACT_BUBBLE, ACT_FLUSH).
//   One sub-module: sat_counter #(W) (en, clr, q).
//     Used for the stall run counter and both perf counters.
//   Top level: action priority decode, state register, data/ctrl registers.
// TESTING
//   1. Reset, then load in_valid=1, ctrl=9'h1A5, lanes {1,2,3,4}.
//      -> next cycle: out_valid=1, ctrl=9'h1A5, data {1,2,3,4}, FULL.
//   2. From FULL, stall_i=1 for 3 cycles while in_data changes.
//      -> outputs frozen, HELD; after release a load with new data -> FULL.
//   3. bubble_i=1 with in_ctrl=9'h1FF, lane0=32'hDEADBEEF.
//      -> out_ctrl=0, out_valid=0, lane0=32'hDEADBEEF, EMPTY.
//   4. stall_i=1 and flush_i=1 on the same edge from HELD.
//      -> all outputs 0, EMPTY, stall run counter cleared.
//   5. STALL_LIMIT=4, stall held 4 edges.
//      -> stall_timeout=1 after the 4th edge; stays 1 after stall drops; rst_n=0 clears it.
//   6. PIPE_STAGE_PERF_EN defined, 70000 stall edges.
//      -> perf_stalls=16'hFFFF and holds.
//      Build without the macro: design compiles, other tests pass unchanged.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers of the 5-stage MIPS core:
// control bundle layout, stage state encoding and the per-edge stage action.
package pipe_pkg;

    localparam int CTRL_W_DEF = 9;

    // Control bundle bit offsets (RegWrite down to ALUOp[1:0])
    localparam int REGWRITE_B = 8;
    localparam int MEMTOREG_B = 7;
    localparam int BRANCH_B   = 6;
    localparam int MEMREAD_B  = 5;
    localparam int MEMWRITE_B = 4;
    localparam int REGDST_B   = 3;
    localparam int ALUSRC_B   = 2;
    localparam int ALUOP_MSB  = 1;
    localparam int ALUOP_LSB  = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_HELD  = 2'd2
    } stage_state_e;

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_STALL  = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_FLUSH  = 2'd3
    } stage_act_e;

    // Resolve the hazard inputs into one action: flush beats stall beats bubble.
    function automatic stage_act_e decode_action(input logic flush,
                                                 input logic stall,
                                                 input logic bubble);
        stage_act_e act;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (stall) begin
            act = ACT_STALL;
        end else if (bubble) begin
            act = ACT_BUBBLE;
        end else begin
            act = ACT_LOAD;
        end
        return act;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);

    // Count register: reset and clear win, then increment unless saturated
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with stall, flush and bubble handling plus a
// sticky stall watchdog. Optional macro PIPE_STAGE_PERF_EN adds two 16-bit
// saturating performance counters (perf_stalls, perf_kills).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DATA_LANES  = 4,
    parameter int CTRL_W      = CTRL_W_DEF,
    parameter int STALL_LIMIT = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall_i,
    input  logic                         flush_i,
    input  logic                         bubble_i,
    input  logic                         in_valid,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [DATA_LANES*DATA_W-1:0] in_data,
    output logic                         out_valid,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [DATA_LANES*DATA_W-1:0] out_data,
    output logic [1:0]                   out_state,
    output logic                         stall_timeout
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]                  perf_stalls,
    output logic [15:0]                  perf_kills
`endif
);

    localparam logic [7:0] RUN_TRIP = 8'(STALL_LIMIT - 1);

    stage_act_e                   act_s;
    stage_state_e                 state_r;
    stage_state_e                 state_nxt_s;
    logic                         valid_nxt_s;
    logic [CTRL_W-1:0]            ctrl_nxt_s;
    logic [DATA_LANES*DATA_W-1:0] data_nxt_s;
    logic                         run_en_s;
    logic                         run_clr_s;
    logic [7:0]                   run_cnt_s;
    logic                         timeout_r;

    // Action decode: one action per edge in priority order
    always_comb begin
        act_s = decode_action(flush_i, stall_i, bubble_i);
    end

    // Next-state and next-contents selection for the stage
    always_comb begin
        state_nxt_s = state_r;
        valid_nxt_s = out_valid;
        ctrl_nxt_s  = out_ctrl;
        data_nxt_s  = out_data;
        case (act_s)
            ACT_FLUSH: begin
                state_nxt_s = ST_EMPTY;
                valid_nxt_s = 1'b0;
                ctrl_nxt_s  = '0;
                data_nxt_s  = '0;
            end
            ACT_STALL: begin
                if (state_r == ST_EMPTY) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_HELD;
                end
            end
            ACT_BUBBLE: begin
                state_nxt_s = ST_EMPTY;
                valid_nxt_s = 1'b0;
                ctrl_nxt_s  = '0;
                data_nxt_s  = in_data;
            end
            ACT_LOAD: begin
                data_nxt_s  = in_data;
                valid_nxt_s = in_valid;
                if (in_valid) begin
                    state_nxt_s = ST_FULL;
                    ctrl_nxt_s  = in_ctrl;
                end else begin
                    state_nxt_s = ST_EMPTY;
                    ctrl_nxt_s  = '0;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
                valid_nxt_s = 1'b0;
                ctrl_nxt_s  = '0;
                data_nxt_s  = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Stage contents: valid, control bundle and data lanes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= valid_nxt_s;
            out_ctrl  <= ctrl_nxt_s;
            out_data  <= data_nxt_s;
        end
    end

    assign out_state = state_r;

    // A stall run only counts while no flush overrides it; anything else ends the run
    always_comb begin
        run_en_s  = stall_i & ~flush_i;
        run_clr_s = ~run_en_s;
    end

    sat_counter #(.W(8)) u_stall_run (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run_en_s),
        .clr   (run_clr_s),
        .q     (run_cnt_s)
    );

    // Sticky watchdog: set on the edge where the run reaches the limit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout_r <= 1'b0;
        end else if (run_en_s && (run_cnt_s >= RUN_TRIP)) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign stall_timeout = timeout_r;

`ifdef PIPE_STAGE_PERF_EN
    logic perf_stall_en_s;
    logic perf_kill_en_s;

    // Perf events: stall edges, and kills that actually discard an instruction
    always_comb begin
        perf_stall_en_s = (act_s == ACT_STALL);
        perf_kill_en_s  = ((act_s == ACT_FLUSH) || (act_s == ACT_BUBBLE)) &&
                          (out_valid || in_valid);
    end

    sat_counter #(.W(16)) u_perf_stalls (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (perf_stall_en_s),
        .clr   (1'b0),
        .q     (perf_stalls)
    );

    sat_counter #(.W(16)) u_perf_kills (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (perf_kill_en_s),
        .clr   (1'b0),
        .q     (perf_kills)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg (STALL_LIMIT=4). The optional
// PIPE_STAGE_PERF_EN build also exercises the perf counters.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int LANES  = 4;
    localparam int CTRL_W = 9;
    localparam int LIMIT  = 4;
    localparam int DW     = DATA_W * LANES;

    typedef struct {
        logic          valid;
        logic [8:0]    ctrl;
        logic [DW-1:0] data;
        logic [1:0]    state;
        logic          timeout;
        logic [15:0]   pstalls;
        logic [15:0]   pkills;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall_i, flush_i, bubble_i, in_valid;
    logic [8:0]    in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [8:0]    out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    out_state;
    logic          stall_timeout;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0]   perf_stalls, perf_kills;
`endif

    int checks_cnt = 0;
    int errors_cnt = 0;
    exp_t sb_q[$];

    // Model state
    logic          m_valid;
    logic [8:0]    m_ctrl;
    logic [DW-1:0] m_data;
    logic [1:0]    m_state;
    int            m_run;
    logic          m_to;
    int            m_pst, m_pk;

    pipe_stage_reg #(
        .DATA_W(DATA_W), .DATA_LANES(LANES), .CTRL_W(CTRL_W), .STALL_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .bubble_i(bubble_i), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_data(in_data), .out_valid(out_valid), .out_ctrl(out_ctrl),
        .out_data(out_data), .out_state(out_state), .stall_timeout(stall_timeout)
`ifdef PIPE_STAGE_PERF_EN
        , .perf_stalls(perf_stalls), .perf_kills(perf_kills)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model one edge, push the expectation, drive, clock, pop and compare
    task automatic step(input logic rst, input logic st, input logic fl, input logic bu,
                        input logic v, input logic [8:0] c, input logic [DW-1:0] d);
        exp_t e;
        exp_t got;
        if (!rst) begin
            m_valid = 1'b0; m_ctrl = 9'd0; m_data = '0; m_state = 2'd0;
            m_run = 0; m_to = 1'b0; m_pst = 0; m_pk = 0;
        end else begin
            if (fl || (!st && bu)) begin
                if ((m_valid || v) && m_pk < 65535) m_pk++;
            end
            if (!fl && st && m_pst < 65535) m_pst++;
            if (st && !fl) begin
                if (m_run < 255) m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run >= LIMIT) m_to = 1'b1;
            if (fl) begin
                m_valid = 1'b0; m_ctrl = 9'd0; m_data = '0; m_state = 2'd0;
            end else if (st) begin
                if (m_state != 2'd0) m_state = 2'd2;
            end else if (bu) begin
                m_valid = 1'b0; m_ctrl = 9'd0; m_data = d; m_state = 2'd0;
            end else begin
                m_valid = v; m_ctrl = v ? c : 9'd0; m_data = d;
                m_state = v ? 2'd1 : 2'd0;
            end
        end
        e.valid = m_valid; e.ctrl = m_ctrl; e.data = m_data; e.state = m_state;
        e.timeout = m_to; e.pstalls = 16'(m_pst); e.pkills = 16'(m_pk);
        sb_q.push_back(e);
        rst_n = rst; stall_i = st; flush_i = fl; bubble_i = bu;
        in_valid = v; in_ctrl = c; in_data = d;
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_eq("valid",   DW'(out_valid),     DW'(got.valid));
        check_eq("ctrl",    DW'(out_ctrl),      DW'(got.ctrl));
        check_eq("data",    out_data,           got.data);
        check_eq("state",   DW'(out_state),     DW'(got.state));
        check_eq("timeout", DW'(stall_timeout), DW'(got.timeout));
`ifdef PIPE_STAGE_PERF_EN
        check_eq("perf_stalls", DW'(perf_stalls), DW'(got.pstalls));
        check_eq("perf_kills",  DW'(perf_kills),  DW'(got.pkills));
`endif
        #4;
    endtask

    function automatic logic [DW-1:0] lanes4(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; bubble_i = 1'b0;
        in_valid = 1'b0; in_ctrl = 9'd0; in_data = '0;
        #2;
        // Reset overrides active inputs
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'h1FF, {DW{1'b1}});
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h0AA, lanes4(32'd9, 32'd9, 32'd9, 32'd9));
        // 1: basic load
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h1A5, lanes4(32'd1, 32'd2, 32'd3, 32'd4));
        // 2: stall three edges with changing inputs, then load
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'(i + 3), lanes4(32'(i), 32'hF0, 32'hF1, 32'hF2));
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h055, lanes4(32'h11, 32'h22, 32'h33, 32'h44));
        // 3: bubble
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9'h1FF, lanes4(32'hDEADBEEF, 32'h5, 32'h6, 32'h7));
        // 4: load, stall to HELD, then stall+flush; short stall run afterwards must not trip
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h0F0, lanes4(32'hA, 32'hB, 32'hC, 32'hD));
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, '0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, '0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 9'h1FF, {DW{1'b1}});
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, '0);
        // Load with in_valid=0 zeroes control; stall from EMPTY stays EMPTY
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h1FF, lanes4(32'h1, 32'h1, 32'h1, 32'h1));
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'h1FF, '0);
        // 5: four-edge stall trips the watchdog; sticky until reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h003, lanes4(32'h7, 32'h8, 32'h9, 32'hA));
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h101, lanes4(32'h1, 32'h2, 32'h3, 32'h4));
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, '0);
        // Random mix
        for (int i = 0; i < 60; i++)
            step(1'b1, ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 4) == 0), 1'($urandom), 9'($urandom),
                 {$urandom, $urandom, $urandom, $urandom});
`ifdef PIPE_STAGE_PERF_EN
        // 6: saturate perf_stalls
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, '0);
        for (int i = 0; i < 70000; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, '0);
        check_eq("perf_stalls_sat", DW'(perf_stalls), DW'(16'hFFFF));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
